pwm_meas: RTL and testbench
===========================

# pwm_meas

Measures the period and high time of an incoming pulse-width-modulated signal. It is the receive-side counterpart of the on-board PWM generator: it recovers `n_high` and the period from a PWM waveform, whether that waveform is looped back from an LED driver or comes from an external source. It sits on the fabric clock with its input synchronized internally. Each completed period is reported once, with a one-cycle valid strobe. A stuck-level detector flags a missing or constant input.

## Interface
Parameters:
- `CNT_W`, 32: width of the internal counters and measurement outputs.
- `TIMEOUT`, 32'h20000: number of cycles without a rising edge before `stuck` asserts. Must satisfy 2 ≤ `TIMEOUT` < 2^`CNT_W`.

Ports:
- `clk`, input, 1: sole clock. All logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: measurement enable. Synchronous to `clk`.
- `pwm_in`, input, 1: PWM signal under test. Asynchronous to `clk`.
- `period`, output, `CNT_W`: cycles between the last two rising edges.
- `n_high`, output, `CNT_W`: cycles high within that period.
- `valid`, output, 1: one-cycle strobe. Asserts when `period` and `n_high` update.
- `stuck`, output, 1: no rising edge seen for `TIMEOUT` cycles.
- `level`, output, 1: synchronized input level, latched when `stuck` asserts.

## Operation
- **Synchronizer.** `pwm_in` passes through two flops to give `s_cur`. A third flop gives `s_prev`. A rise is the condition `s_cur & ~s_prev`.
- **Counters.** `per_cnt` and `hi_cnt` are both `CNT_W` wide. They update only in state MEASURE.
- **States.**
  - IDLE: entered on reset, or on any cycle where `en`=0.
  - WAIT_RISE: entered from IDLE when `en`=1, or from MEASURE on timeout.
  - MEASURE: entered from WAIT_RISE on a rise.
- **IDLE.** Counters are cleared. `valid`=0 and `stuck`=0. `period`, `n_high` and `level` hold their last values.
- **WAIT_RISE.**
  - On a rise: `per_cnt` is set to 1, `hi_cnt` is set to 1, and the state goes to MEASURE.
  - The partial period before this first rise is discarded, so no `valid` is issued.
- **MEASURE, on a rise:**
  - `period` is loaded with `per_cnt` and `n_high` is loaded with `hi_cnt`.
  - `valid` pulses on the next cycle.
  - `per_cnt` is set to 1 and `hi_cnt` is set to 1.
  - `stuck` is cleared.
- **MEASURE, on a non-rise cycle:**
  - `per_cnt` increments by 1.
  - `hi_cnt` increments by `s_cur`.
- **Timeout.** If `per_cnt` = `TIMEOUT` on a non-rise cycle in MEASURE:
  - `stuck` is set to 1, `level` is loaded with `s_cur`, and the state goes to WAIT_RISE.
  - `period` and `n_high` are not updated.
- **WAIT_RISE timeout.** WAIT_RISE also counts in `per_cnt`. If no rise arrives within `TIMEOUT` cycles, `stuck` is set to 1, `level` is loaded with `s_cur`, and the state remains WAIT_RISE.
  - `stuck` then stays 1 until the first valid measurement.
  - The WAIT_RISE count saturates at `TIMEOUT`.
- **No wrap.** Counters never exceed `TIMEOUT`, so no wrap-around is possible.
- **Invariant.** `n_high` ≤ `period` always holds.
- **Reset values.** All outputs are 0 and the state is IDLE. This includes synchronizer flops, counters, `period`, `n_high`, `valid`, `stuck` and `level`.

## Timing
- **Latency.** `valid` is high in the cycle after the 3rd rising clock edge, counted from the first edge that samples `pwm_in`=1. That is 2 synchronizer edges plus 1 output register edge.
- **Strobe.** `valid` is exactly one cycle wide.
- **Update order.** `period` and `n_high` change on the same edge that sets `valid`. They hold until the next `valid`.
- **Strobe spacing.** The minimum spacing between `valid` strobes is 2 cycles, for an input period of 2 with 1 cycle high.
- **Simultaneous events.**
  - `en` falling on a rise cycle: `en`=0 wins. No `valid` is issued and the state goes to IDLE.
  - Timeout coinciding with a rise: the rise wins.
- **Reset mid-operation.** Asserting `rst` takes effect immediately. An in-progress period is lost and no `valid` is issued. After deassertion, the first rise is again discarded.
- **Pulse width limit.** Pulses or gaps narrower than 1 clock period may be missed. This is acceptable.

## Test plan
- **Nominal PWM.** Drive PWM with period 0x10000 and high time 0x4000. Hold `en`=1.
  - The first rise produces no `valid`.
  - Every later `valid` is spaced 65536 cycles apart, with `period`=0x10000, `n_high`=0x4000 and `stuck`=0.
- **Minimum period.** Drive a period of 2 with high time 1.
  - `valid` pulses every 2 cycles with `period`=2 and `n_high`=1.
  - Latency from the first sampled high to the first `valid` is 3 edges plus the discarded first period.
- **Stuck low.** Hold `pwm_in` at 0 after a nominal run.
  - `stuck`=1 and `level`=0 exactly `TIMEOUT` cycles after the last rise's counter reload.
  - `period` and `n_high` keep their last values.
  - Resume PWM: `stuck` clears at the second rise, together with `valid`.
- **Stuck high.** Hold `pwm_in` at 1. `stuck`=1 and `level`=1 after `TIMEOUT` cycles.
- **Reset mid-period.** Assert `rst` at cycle 0x8000 of a nominal period.
  - All outputs go to 0 immediately.
  - After release, the first post-reset `valid` reports 0x10000/0x4000, and occurs one full period after the first post-reset rise.
- **Enable deasserted.** Drop `en` for 100 cycles mid-period.
  - No `valid` is issued and the outputs hold.
  - After re-enable, the first rise is discarded and the next one reports correct values.

Source files
------------

// File: rtl/pwm_meas.sv
// PWM receiver: recovers period and high time of an asynchronous PWM input,
// with a one-cycle valid strobe per completed period and a stuck-level flag.
module pwm_meas #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 32'h20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] n_high,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic             s_meta_reg;
  logic             s_cur;
  logic             s_prev;
  logic             rise;

  logic [CNT_W-1:0] per_cnt_reg;
  logic [CNT_W-1:0] hi_cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] n_high_reg;
  logic             valid_reg;
  logic             stuck_reg;
  logic             level_reg;

  logic             cnt_clr;
  logic             cnt_load;
  logic             per_inc;
  logic             hi_inc;
  logic             meas_done;
  logic             timeout_hit;
  logic             at_limit;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta_reg <= 1'b0;
      s_cur      <= 1'b0;
      s_prev     <= 1'b0;
    end else begin
      s_meta_reg <= pwm_in;
      s_cur      <= s_meta_reg;
      s_prev     <= s_cur;
    end
  end

  assign rise     = s_cur & ~s_prev;
  assign at_limit = (per_cnt_reg == TO_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      state_next = WAIT_RISE;
        WAIT_RISE: if (rise) state_next = MEASURE;
        MEASURE:   if (!rise && at_limit) state_next = WAIT_RISE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // A rise always beats a coincident timeout; en=0 suppresses every action.
  always_comb begin
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    per_inc     = 1'b0;
    hi_inc      = 1'b0;
    meas_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_clr = 1'b1;
      end
      WAIT_RISE: begin
        if (en) begin
          if (rise) begin
            cnt_load = 1'b1;
          end else if (at_limit) begin
            timeout_hit = ~stuck_reg;
          end else begin
            per_inc = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (en) begin
          if (rise) begin
            cnt_load  = 1'b1;
            meas_done = 1'b1;
          end else if (at_limit) begin
            timeout_hit = 1'b1;
          end else begin
            per_inc = 1'b1;
            hi_inc  = 1'b1;
          end
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else if (cnt_clr) begin
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
    end else if (cnt_load) begin
      per_cnt_reg <= ONE;
      hi_cnt_reg  <= ONE;
    end else begin
      if (per_inc) per_cnt_reg <= per_cnt_reg + ONE;
      if (hi_inc)  hi_cnt_reg  <= hi_cnt_reg + CNT_W'(s_cur);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg <= '0;
      n_high_reg <= '0;
      valid_reg  <= 1'b0;
      stuck_reg  <= 1'b0;
      level_reg  <= 1'b0;
    end else begin
      valid_reg <= meas_done;
      if (meas_done) begin
        period_reg <= per_cnt_reg;
        n_high_reg <= hi_cnt_reg;
      end
      if (state_reg == IDLE || meas_done) begin
        stuck_reg <= 1'b0;
      end else if (timeout_hit) begin
        stuck_reg <= 1'b1;
        level_reg <= s_cur;
      end
    end
  end

  assign period = period_reg;
  assign n_high = n_high_reg;
  assign valid  = valid_reg;
  assign stuck  = stuck_reg;
  assign level  = level_reg;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas with a scaled-down timeout and PWM period.
module tb_pwm_meas;

  localparam int CNT_W = 16;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] n_high;
  logic             valid;
  logic             stuck;
  logic             level;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int last_gap = 0;
  logic stuck_at_valid = 1'b0;
  logic [CNT_W-1:0] per_hist [256];
  logic [CNT_W-1:0] hi_hist  [256];
  int base;

  pwm_meas #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pwm_in (pwm_in),
    .period (period),
    .n_high (n_high),
    .valid  (valid),
    .stuck  (stuck),
    .level  (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      per_hist[valid_cnt % 256] = period;
      hi_hist[valid_cnt % 256]  = n_high;
      if (valid_cnt > 0) last_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      stuck_at_valid = stuck;
      valid_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("check %s got=%0h ok", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_periods(input int n, input int p, input int h);
    repeat (n) begin
      pwm_in = 1'b1;
      step(h);
      pwm_in = 1'b0;
      step(p - h);
    end
  endtask

  task automatic wait_stuck();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!stuck && i < 300);
    chk("stuck_seen", 32'(stuck), 32'd1);
  endtask

  initial begin
    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_n_high", 32'(n_high), 32'd0);
    chk("rst_valid",  32'(valid),  32'd0);
    chk("rst_stuck",  32'(stuck),  32'd0);
    chk("rst_level",  32'(level),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    step(10);

    // Nominal 16/4: first rise discarded
    base = valid_cnt;
    run_periods(5, 16, 4);
    step(4);
    chk("nom_count",  32'(valid_cnt - base), 32'd4);
    chk("nom_period", 32'(period), 32'd16);
    chk("nom_n_high", 32'(n_high), 32'd4);
    chk("nom_gap",    32'(last_gap), 32'd16);
    chk("nom_stuck",  32'(stuck), 32'd0);

    // Minimum period 2/1; first report closes the stretched 20-cycle period
    base = valid_cnt;
    run_periods(6, 2, 1);
    step(4);
    chk("min_count",  32'(valid_cnt - base), 32'd6);
    chk("min_first_period", 32'(per_hist[base % 256]), 32'd20);
    chk("min_first_n_high", 32'(hi_hist[base % 256]), 32'd4);
    chk("min_period", 32'(period), 32'd2);
    chk("min_n_high", 32'(n_high), 32'd1);
    chk("min_gap",    32'(last_gap), 32'd2);

    // Stuck low
    wait_stuck();
    chk("stl_delay",  32'(cyc - last_valid_cyc), 32'(TO));
    chk("stl_level",  32'(level), 32'd0);
    chk("stl_period", 32'(period), 32'd2);
    chk("stl_n_high", 32'(n_high), 32'd1);
    step(1);

    // Resume: stuck clears at second rise together with valid
    base = valid_cnt;
    run_periods(1, 16, 4);
    chk("res_still_stuck", 32'(stuck), 32'd1);
    chk("res_no_valid", 32'(valid_cnt - base), 32'd0);
    run_periods(1, 16, 4);
    chk("res_count",  32'(valid_cnt - base), 32'd1);
    chk("res_stuck_at_valid", 32'(stuck_at_valid), 32'd0);
    chk("res_stuck",  32'(stuck), 32'd0);
    chk("res_period", 32'(period), 32'd16);
    chk("res_n_high", 32'(n_high), 32'd4);

    // Stuck high
    pwm_in = 1'b1;
    wait_stuck();
    chk("sth_delay",  32'(cyc - last_valid_cyc), 32'(TO));
    chk("sth_level",  32'(level), 32'd1);
    chk("sth_period", 32'(period), 32'd16);
    chk("sth_n_high", 32'(n_high), 32'd4);
    step(1);

    // Reset mid-period
    pwm_in = 1'b0;
    step(5);
    run_periods(3, 16, 4);
    pwm_in = 1'b1;
    step(4);
    pwm_in = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    chk("mrst_period", 32'(period), 32'd0);
    chk("mrst_n_high", 32'(n_high), 32'd0);
    chk("mrst_valid",  32'(valid),  32'd0);
    chk("mrst_stuck",  32'(stuck),  32'd0);
    chk("mrst_level",  32'(level),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8);
    base = valid_cnt;
    run_periods(3, 16, 4);
    step(4);
    chk("mrst_count", 32'(valid_cnt - base), 32'd2);
    chk("mrst_first_period", 32'(per_hist[base % 256]), 32'd16);
    chk("mrst_first_n_high", 32'(hi_hist[base % 256]), 32'd4);
    chk("mrst_gap", 32'(last_gap), 32'd16);

    // en drops exactly on a rise cycle, then stays low one period
    base = valid_cnt;
    pwm_in = 1'b1;
    step(2);
    en = 1'b0;
    step(2);
    pwm_in = 1'b0;
    step(12);
    run_periods(1, 16, 4);
    step(4);
    chk("en_no_valid", 32'(valid_cnt - base), 32'd0);
    chk("en_period",   32'(period), 32'd16);
    chk("en_n_high",   32'(n_high), 32'd4);
    chk("en_stuck",    32'(stuck), 32'd0);
    en = 1'b1;
    step(3);
    run_periods(3, 16, 4);
    step(4);
    chk("en_count",  32'(valid_cnt - base), 32'd2);
    chk("en_period_after", 32'(period), 32'd16);
    chk("en_n_high_after", 32'(n_high), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
